// File: rtl/playfield_row_ctrl.sv
// One playfield row: WIDTH cells of COLOR_W bits with row shift, masked 4-cell write,
// wall-aware hitbox lookup, registered GPU read and a flash-then-erase line-clear FSM.
module playfield_row_ctrl #(
    parameter int unsigned WIDTH        = 12,
    parameter int unsigned COLOR_W      = 3,
    parameter int unsigned ROW_ID       = 0,
    parameter int unsigned ROW_BITS     = 6,
    parameter int unsigned COL_BITS     = 6,
    parameter int unsigned FLASH_CYCLES = 8,
    parameter int unsigned FLASH_COLOR  = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       advance,
    input  logic [WIDTH*COLOR_W-1:0]   shift_in,
    output logic [WIDTH*COLOR_W-1:0]   shift_out,
    input  logic                       wr_en,
    input  logic [ROW_BITS-1:0]        wr_row,
    input  logic [4*COL_BITS-1:0]      wr_cols,
    input  logic [3:0]                 wr_mask,
    input  logic [COLOR_W-1:0]         wr_color,
    input  logic [4*COL_BITS-1:0]      hit_cols,
    output logic [3:0]                 hit_status,
    output logic                       row_full,
    input  logic [COL_BITS-1:0]        rd_col,
    output logic [COLOR_W-1:0]         rd_color,
    input  logic                       clr_start,
    output logic                       clr_busy,
    output logic                       clr_done
);

    localparam int unsigned CNT_W = $clog2(FLASH_CYCLES) + 1;
    localparam int unsigned ROW_W = WIDTH * COLOR_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StFlash} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COLOR_W-1:0]   rd_color_q, rd_color_d;
    logic                 clr_done_q, clr_done_d;
    logic [WIDTH-1:0]     occupied;

    always_comb begin
        occupied = '0;
        for (int i = 0; i < WIDTH; i++) begin
            occupied[i] = |row_q[i*COLOR_W +: COLOR_W];
        end
    end

    assign row_full  = &occupied;
    assign shift_out = row_q;
    assign clr_busy  = (state_q == StFlash);
    assign clr_done  = clr_done_q;
    assign rd_color  = rd_color_q;

    // A probe that matches no in-range column is a wall.
    always_comb begin
        hit_status = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (hit_cols[k*COL_BITS +: COL_BITS] == COL_BITS'(i)) begin
                    hit_status[k] = occupied[i];
                end
            end
        end
    end

    always_comb begin
        rd_color_d = '0;
        if (state_q == StFlash) begin
            rd_color_d = COLOR_W'(FLASH_COLOR);
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (rd_col == COL_BITS'(i)) begin
                    rd_color_d = row_q[i*COLOR_W +: COLOR_W];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        clr_done_d = 1'b0;

        if (advance) begin
            // Gravity wins over everything and silently aborts a pending clear.
            row_d   = shift_in;
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wr_en && (wr_row == ROW_BITS'(ROW_ID))) begin
                        for (int k = 0; k < 4; k++) begin
                            for (int i = 0; i < WIDTH; i++) begin
                                if (wr_mask[k] && (wr_cols[k*COL_BITS +: COL_BITS] == COL_BITS'(i))) begin
                                    row_d[i*COLOR_W +: COLOR_W] = wr_color;
                                end
                            end
                        end
                    end
                    if (clr_start && row_full) begin
                        state_d = StFlash;
                        cnt_d   = '0;
                    end
                end
                StFlash: begin
                    if (cnt_q == CNT_LAST) begin
                        row_d      = '0;
                        clr_done_d = 1'b1;
                        state_d    = StIdle;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            row_q      <= '0;
            rd_color_q <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            rd_color_q <= rd_color_d;
            clr_done_q <= clr_done_d;
        end
    end

endmodule

// File: tb/tb_playfield_row_ctrl.sv
// Directed plus random stimulus for playfield_row_ctrl, checked against an array-based row model.
module tb_playfield_row_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance;
    logic [35:0] shift_in;
    logic [35:0] shift_out;
    logic        wr_en;
    logic [5:0]  wr_row;
    logic [23:0] wr_cols;
    logic [3:0]  wr_mask;
    logic [2:0]  wr_color;
    logic [23:0] hit_cols;
    logic [3:0]  hit_status;
    logic        row_full;
    logic [5:0]  rd_col;
    logic [2:0]  rd_color;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;

    int errors = 0;
    int checks = 0;

    // Model: cell colours, cycles of flash remaining, last done pulse, last GPU read.
    int       m_cells[12];
    int       m_flash_left;
    bit       m_done;
    int       m_rd;

    playfield_row_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .advance    (advance),
        .shift_in   (shift_in),
        .shift_out  (shift_out),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_cols    (wr_cols),
        .wr_mask    (wr_mask),
        .wr_color   (wr_color),
        .hit_cols   (hit_cols),
        .hit_status (hit_status),
        .row_full   (row_full),
        .rd_col     (rd_col),
        .rd_color   (rd_color),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_full();
        for (int i = 0; i < 12; i++) if (m_cells[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [35:0] m_shift();
        logic [35:0] v = '0;
        for (int i = 0; i < 12; i++) v[i*3 +: 3] = 3'(m_cells[i]);
        return v;
    endfunction

    function automatic logic [3:0] m_hit(input logic [23:0] hc);
        logic [3:0] h;
        int c;
        for (int k = 0; k < 4; k++) begin
            c = int'(hc[k*6 +: 6]);
            h[k] = (c >= 12) ? 1'b1 : (m_cells[c] != 0);
        end
        return h;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 12; i++) m_cells[i] = 0;
        m_flash_left = 0;
        m_done = 1'b0;
        m_rd = 0;
    endtask

    task automatic check_all();
        chk("shift_out", 64'(shift_out), 64'(m_shift()));
        chk("row_full", 64'(row_full), 64'(m_full()));
        chk("hit_status", 64'(hit_status), 64'(m_hit(hit_cols)));
        chk("clr_busy", 64'(clr_busy), 64'(m_flash_left > 0));
        chk("clr_done", 64'(clr_done), 64'(m_done));
        chk("rd_color", 64'(rd_color), 64'(m_rd));
    endtask

    // Apply one clock edge to the model with the current inputs, then compare.
    task automatic step();
        int  nrd;
        bit  full;
        int  c;
        full = m_full();
        if (m_flash_left > 0) nrd = 7;
        else if (rd_col >= 12) nrd = 0;
        else nrd = m_cells[rd_col];
        m_done = 1'b0;
        if (advance) begin
            for (int i = 0; i < 12; i++) m_cells[i] = int'(shift_in[i*3 +: 3]);
            m_flash_left = 0;
        end else if (m_flash_left > 0) begin
            if (m_flash_left == 1) begin
                for (int i = 0; i < 12; i++) m_cells[i] = 0;
                m_done = 1'b1;
            end
            m_flash_left--;
        end else begin
            if (wr_en && wr_row == 0) begin
                for (int k = 0; k < 4; k++) begin
                    c = int'(wr_cols[k*6 +: 6]);
                    if (wr_mask[k] && c < 12) m_cells[c] = int'(wr_color);
                end
            end
            if (clr_start && full) m_flash_left = 8;
        end
        m_rd = nrd;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        advance = 0; shift_in = '0; wr_en = 0; wr_row = 0; wr_cols = '0; wr_mask = 0;
        wr_color = 0; clr_start = 0;
    endtask

    task automatic write4(input int c3, input int c2, input int c1, input int c0,
                          input int color);
        wr_en = 1; wr_row = 0; wr_mask = 4'b1111; wr_color = 3'(color);
        wr_cols = {6'(c3), 6'(c2), 6'(c1), 6'(c0)};
        step();
        wr_en = 0;
    endtask

    task automatic fill_row();
        write4(3, 2, 1, 0, 4);
        write4(7, 6, 5, 4, 1);
        write4(11, 10, 9, 8, 2);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        reset = 0;
        idle_inputs();
        hit_cols = '0;
        rd_col = 0;
        m_reset();
        #12;
        check_all();
        reset = 1;

        // 1: write colour 5 to cols 0..3, probe {12,4,3,0}
        hit_cols = {6'd12, 6'd4, 6'd3, 6'd0};
        write4(3, 2, 1, 0, 5);
        chk("t1_hit", 64'(hit_status), 64'(4'b1011));

        // 2: wrong row and out-of-range column are ignored
        wr_en = 1; wr_row = 6'd1; wr_mask = 4'b1111; wr_color = 3'd6;
        wr_cols = {6'd4, 6'd5, 6'd6, 6'd7};
        step();
        wr_row = 0; wr_cols = {4{6'd15}};
        step();
        wr_en = 0;
        chk("t2_full", 64'(row_full), 64'(0));

        // 3: full row flashes for 8 cycles then erases
        fill_row();
        rd_col = 6'd5;
        clr_start = 1;
        step();
        clr_start = 0;
        busy_cnt = clr_busy ? 1 : 0;
        done_cnt = 0;
        for (int n = 0; n < 20 && done_cnt == 0; n++) begin
            step();
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        chk("t3_busy_cycles", 64'(busy_cnt), 64'(8));
        chk("t3_done_seen", 64'(done_cnt), 64'(1));
        step();
        chk("t3_done_pulse", 64'(clr_done), 64'(0));
        chk("t3_shift_out", 64'(shift_out), 64'(0));

        // 4: clear on a non-full row is ignored; write during flash is dropped
        write4(3, 2, 1, 0, 3);
        clr_start = 1;
        step();
        clr_start = 0;
        chk("t4_not_busy", 64'(clr_busy), 64'(0));
        fill_row();
        clr_start = 1;
        step();
        clr_start = 0;
        wr_cols = {6'd0, 6'd0, 6'd0, 6'd0}; wr_mask = 4'b0001; wr_color = 0; wr_en = 1;
        step();
        wr_en = 0;
        for (int n = 0; n < 8; n++) step();

        // 5: advance aborts the flash; advance beats a same-edge write
        fill_row();
        clr_start = 1;
        step();
        clr_start = 0;
        for (int n = 0; n < 3; n++) step();
        advance = 1; shift_in = {12{3'd2}};
        step();
        chk("t5_cell0", 64'(shift_out[2:0]), 64'(2));
        advance = 1; shift_in = {12{3'd1}};
        wr_en = 1; wr_row = 0; wr_cols = {6'd3, 6'd2, 6'd1, 6'd0}; wr_mask = 4'b1111;
        wr_color = 3'd6;
        step();
        idle_inputs();
        step();

        // 6: asynchronous reset mid-flash
        clr_start = 1;
        step();
        clr_start = 0;
        rd_col = 6'd11;
        step();
        step();
        #3 reset = 0;
        #1;
        chk("t6_shift_out", 64'(shift_out), 64'(0));
        chk("t6_rd_color", 64'(rd_color), 64'(0));
        chk("t6_busy", 64'(clr_busy), 64'(0));
        chk("t6_done", 64'(clr_done), 64'(0));
        m_reset();
        #2 reset = 1;
        write4(11, 11, 11, 11, 3);
        step();
        chk("t6_rd11", 64'(rd_color), 64'(3));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            advance   = ($urandom_range(0, 11) == 0);
            for (int i = 0; i < 12; i++) shift_in[i*3 +: 3] = 3'($urandom_range(0, 7));
            wr_en     = $urandom_range(0, 1) == 1;
            wr_row    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            for (int k = 0; k < 4; k++) begin
                wr_cols[k*6 +: 6]  = 6'($urandom_range(0, 15));
                hit_cols[k*6 +: 6] = 6'($urandom_range(0, 15));
            end
            wr_mask   = 4'($urandom_range(0, 15));
            wr_color  = 3'($urandom_range(0, 7));
            rd_col    = 6'($urandom_range(0, 15));
            clr_start = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
